// File: rtl/shl_rr_arbiter.sv
// Round-robin arbiter that time-shares one registered left shifter among NREQ requesters.
// Each grant runs a fixed IDLE -> EXEC -> RESP sequence and returns a one-hot done pulse.
module shl_rr_arbiter #(
  parameter int unsigned DATAWIDTH = 8,
  parameter int unsigned NREQ      = 4
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*DATAWIDTH-1:0] a_in,
  input  logic [NREQ*DATAWIDTH-1:0] sh_in,
  output logic [NREQ-1:0]           gnt,
  output logic [NREQ-1:0]           done,
  output logic [DATAWIDTH-1:0]      d,
  output logic                      busy
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [PW-1:0]        r_ptr;
  logic [PW-1:0]        r_k;
  logic [DATAWIDTH-1:0] r_op_a;
  logic [DATAWIDTH-1:0] r_op_sh;
  logic [NREQ-1:0]      r_gnt;
  logic [NREQ-1:0]      r_done;
  logic [DATAWIDTH-1:0] r_d;

  logic                 w_found;
  logic [PW-1:0]        w_sel;
  logic [PW-1:0]        w_cand;
  logic [PW-1:0]        w_ptr_nxt;
  logic [DATAWIDTH-1:0] w_a_sel;
  logic [DATAWIDTH-1:0] w_sh_sel;
  logic                 w_take;

  // Search upward from the pointer, wrapping; the first set request wins.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_cand  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_cand = PW'((32'(r_ptr) + i) % NREQ);
      if (!w_found && req[w_cand]) begin
        w_found = 1'b1;
        w_sel   = w_cand;
      end
    end
  end

  always_comb begin
    w_a_sel  = '0;
    w_sh_sel = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (PW'(i) == w_sel) begin
        w_a_sel  = a_in[i*DATAWIDTH +: DATAWIDTH];
        w_sh_sel = sh_in[i*DATAWIDTH +: DATAWIDTH];
      end
    end
  end

  assign w_ptr_nxt = (w_sel == PW'(NREQ-1)) ? '0 : w_sel + PW'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_found) begin
          w_take      = 1'b1;
          w_state_nxt = EXEC;
        end
      end
      EXEC:    w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A logical left shift by >= DATAWIDTH already yields zero, covering overshift.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_ptr   <= '0;
      r_k     <= '0;
      r_op_a  <= '0;
      r_op_sh <= '0;
      r_gnt   <= '0;
      r_done  <= '0;
      r_d     <= '0;
    end else begin
      r_gnt  <= '0;
      r_done <= '0;
      if (w_take) begin
        r_op_a  <= w_a_sel;
        r_op_sh <= w_sh_sel;
        r_k     <= w_sel;
        r_ptr   <= w_ptr_nxt;
        r_gnt   <= {{(NREQ-1){1'b0}}, 1'b1} << w_sel;
      end
      if (r_state == EXEC) begin
        r_d    <= r_op_a << r_op_sh;
        r_done <= {{(NREQ-1){1'b0}}, 1'b1} << r_k;
      end
    end
  end

  assign gnt  = r_gnt;
  assign done = r_done;
  assign d    = r_d;
  assign busy = (r_state != IDLE);

endmodule

// File: tb/tb_shl_rr_arbiter.sv
// Directed bench for shl_rr_arbiter: reset, round-robin order, pointer wrap, shift results, operand capture.
module tb_shl_rr_arbiter;

  localparam int unsigned DW = 8;
  localparam int unsigned NR = 4;

  logic             Clk;
  logic             Rst;
  logic [NR-1:0]    req;
  logic [NR*DW-1:0] a_in;
  logic [NR*DW-1:0] sh_in;
  logic [NR-1:0]    gnt;
  logic [NR-1:0]    done;
  logic [DW-1:0]    d;
  logic             busy;

  int unsigned n_vec;
  int unsigned n_err;

  shl_rr_arbiter #(.DATAWIDTH(DW), .NREQ(NR)) u_dut (
    .Clk   (Clk),
    .Rst   (Rst),
    .req   (req),
    .a_in  (a_in),
    .sh_in (sh_in),
    .gnt   (gnt),
    .done  (done),
    .d     (d),
    .busy  (busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One full transaction, starting and ending at an IDLE negedge.
  task automatic do_op(input string tag, input logic [NR-1:0] r, input logic [NR*DW-1:0] a_after,
                       input logic [NR-1:0] exp_gnt, input logic [DW-1:0] exp_d);
    req = r;
    @(negedge Clk);
    chk({tag, ".gnt"},  32'(gnt),  32'(exp_gnt));
    chk({tag, ".busy1"}, 32'(busy), 32'd1);
    chk({tag, ".done0"}, 32'(done), 32'd0);
    req  = '0;
    a_in = a_after;
    @(negedge Clk);
    chk({tag, ".gnt0"}, 32'(gnt),  32'd0);
    chk({tag, ".done"}, 32'(done), 32'(exp_gnt));
    chk({tag, ".d"},    32'(d),    32'(exp_d));
    chk({tag, ".busy2"}, 32'(busy), 32'd1);
    @(negedge Clk);
    chk({tag, ".done_clr"}, 32'(done), 32'd0);
    chk({tag, ".idle"},     32'(busy), 32'd0);
    chk({tag, ".d_hold"},   32'(d),    32'(exp_d));
  endtask

  logic [NR-1:0]    rr_seq [5];
  logic [NR*DW-1:0] a_tmp;

  initial begin
    n_vec  = 0;
    n_err  = 0;
    rr_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    Rst    = 1'b1;
    req    = 4'b1111;
    a_in   = '0;
    sh_in  = '0;
    #12;
    chk("rst.gnt",  32'(gnt),  32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.d",    32'(d),    32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    @(negedge Clk);
    Rst = 1'b0;

    // req held at all-ones: grants 0,1,2,3,0 every third cycle
    for (int c = 0; c < 15; c++) begin
      @(negedge Clk);
      chk($sformatf("rr.gnt%0d", c),  32'(gnt),  (c % 3 == 0) ? 32'(rr_seq[c/3]) : 32'd0);
      chk($sformatf("rr.done%0d", c), 32'(done), (c % 3 == 1) ? 32'(rr_seq[c/3]) : 32'd0);
      if (c == 12) req = '0;
    end

    a_in[2*DW +: DW]  = 8'h13;
    sh_in[2*DW +: DW] = 8'd3;
    do_op("single", 4'b0100, a_in, 4'b0100, 8'h98);

    a_in[0*DW +: DW]  = 8'h05;
    sh_in[0*DW +: DW] = 8'd1;
    a_in[1*DW +: DW]  = 8'h03;
    sh_in[1*DW +: DW] = 8'd2;
    do_op("wrap0", 4'b0011, a_in, 4'b0001, 8'h0A);
    do_op("wrap1", 4'b0011, a_in, 4'b0010, 8'h0C);

    a_in[3*DW +: DW]  = 8'hFF;
    sh_in[3*DW +: DW] = 8'd8;
    do_op("ovsh8", 4'b1000, a_in, 4'b1000, 8'h00);
    a_in[3*DW +: DW]  = 8'h81;
    sh_in[3*DW +: DW] = 8'd1;
    do_op("trunc", 4'b1000, a_in, 4'b1000, 8'h02);
    a_in[3*DW +: DW]  = 8'hFF;
    sh_in[3*DW +: DW] = 8'hFF;
    do_op("ovshFF", 4'b1000, a_in, 4'b1000, 8'h00);

    a_in[0*DW +: DW]  = 8'h01;
    sh_in[0*DW +: DW] = 8'd4;
    a_tmp = a_in;
    a_tmp[0*DW +: DW] = 8'h80;
    do_op("capture", 4'b0001, a_tmp, 4'b0001, 8'h10);

    // Reset during EXEC discards the operation
    a_in[1*DW +: DW]  = 8'h0F;
    sh_in[1*DW +: DW] = 8'd2;
    req = 4'b0010;
    @(negedge Clk);
    chk("midrst.gnt", 32'(gnt), 32'b0010);
    req = '0;
    #2 Rst = 1'b1;
    #1;
    chk("midrst.gnt0", 32'(gnt),  32'd0);
    chk("midrst.done", 32'(done), 32'd0);
    chk("midrst.d",    32'(d),    32'd0);
    chk("midrst.busy", 32'(busy), 32'd0);
    @(negedge Clk);
    Rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge Clk);
      chk($sformatf("midrst.nodone%0d", c), 32'(done), 32'd0);
      chk($sformatf("midrst.d%0d", c),      32'(d),    32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/shl_rr_arbiter.md
Name: shl_rr_arbiter

Overview:
- Round-robin arbiter and sequencer sharing one left-shift datapath among NREQ requesters.
- Each requester presents an operand and a shift amount with a request.
- The block grants one requester at a time, captures its operands, and registers the result a << sh_amt.
- It returns the result with a one-hot done pulse to the granted requester.
- Sits between the scheduled datapath's consumers and the single shared SHL resource.

Parameters:
- DATAWIDTH, 8, width of operand, shift amount and result.
- NREQ, 4, number of requesters; legal range 2..8.

Ports:
- Clk  input  1  rising-edge clock.
- Rst  input  1  asynchronous, active-high reset.
- req  input  NREQ  per-requester request, level-sensitive.
- a_in  input  NREQ*DATAWIDTH  flattened operands; requester i occupies bits [i*DATAWIDTH +: DATAWIDTH].
- sh_in  input  NREQ*DATAWIDTH  flattened shift amounts, same packing.
- gnt  output  NREQ  registered one-hot grant, one-cycle pulse.
- done  output  NREQ  registered one-hot completion, one-cycle pulse.
- d  output  DATAWIDTH  registered result; valid in the cycle done is high, held until the next result.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (asynchronous, Rst=1):
  - state=IDLE.
  - gnt=0, done=0, d=0, busy=0.
  - Operand registers=0.
  - Round-robin pointer=0.
  - Any in-flight operation is discarded with no done pulse.
- FSM states IDLE -> EXEC -> RESP -> IDLE. Fixed 3 cycles per operation; no back-to-back overlap.
- IDLE:
  - If req != 0, at the rising edge:
    - Select index k = first set req bit searching from pointer upward, wrapping modulo NREQ.
    - Latch op_a=a_in[k], op_sh=sh_in[k], and k.
    - gnt <= onehot(k).
    - pointer <= (k+1) mod NREQ.
    - state <= EXEC.
  - If req == 0: remain in IDLE, gnt=0.
- EXEC:
  - gnt <= 0.
  - d <= op_a << op_sh, truncated to DATAWIDTH; op_sh treated as unsigned, and op_sh >= DATAWIDTH yields 0.
  - done <= onehot(k).
  - state <= RESP.
- RESP:
  - done and d visible during this cycle.
  - done <= 0.
  - state <= IDLE.
- Latency: req sampled at edge T -> gnt high in cycle T..T+1, done and d valid in cycle T+1..T+2. Next grant is possible at edge T+3.
- Operands are sampled only at the grant edge. Changes to a_in/sh_in after the grant do not affect the result.
- Requester protocol:
  - Hold req until gnt is seen, then drop it.
  - If req is still high when the FSM returns to IDLE, it is treated as a new request.
- Requests arriving or dropping during EXEC/RESP are ignored. Only the req value at the IDLE edge matters.
- Simultaneous requests are resolved strictly by the rotating pointer, so no requester starves. Worst-case wait is (NREQ-1) operations.
- The pointer wraps from NREQ-1 to 0.
- Exactly one bit of gnt/done is high at most, and never both gnt and done in the same cycle.
- d holds its last value between results and is 0 after reset.

Test Plan:
- Reset/idle:
  - Stimulus: Rst pulse mid-EXEC, after req[1] was granted with a=8'h0F, sh=2.
  - Required: gnt=0, done=0, d=8'h00, busy=0 immediately; no done[1] afterwards.
- Single request:
  - Stimulus: req=4'b0100, a_in[2]=8'h13, sh_in[2]=3.
  - Required: gnt=4'b0100 in the cycle after the edge; next cycle done=4'b0100 and d=8'h98; busy high for 2 cycles.
- Round robin:
  - Stimulus: req=4'b1111 held continuously from reset.
  - Required: grants in order 0,1,2,3,0, spaced exactly 3 cycles apart.
- Pointer skip/wrap:
  - Stimulus: pointer=3 after granting 2, then req=4'b0011.
  - Required: grant 0, then 1.
- Overshift and truncation:
  - Stimulus 1: a=8'hFF, sh=8 -> required d=8'h00.
  - Stimulus 2: a=8'h81, sh=1 -> required d=8'h02.
  - Stimulus 3: sh=8'hFF -> required d=8'h00.
- Operand capture:
  - Stimulus: change a_in[0] from 8'h01 to 8'h80 in the cycle after gnt[0], with sh=4.
  - Required: d=8'h10.
